// File: rtl/uart_cmd_ctrl_if.sv
// Shared-memory port and transmitter handshake of the UART command sequencer.
// The sequencer drives the master side; the memory and transmitter drive the slave side.
interface uart_cmd_ctrl_if #(
    parameter int AW = 16
);
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [7:0]    mem_wdat;
    logic [7:0]    mem_rdat;
    logic [7:0]    tx_dat;
    logic          tx_st;
    logic          tx_busy;

    modport master (
        output mem_adr, mem_we, mem_wdat, tx_dat, tx_st,
        input  mem_rdat, tx_busy
    );

    modport slave (
        input  mem_adr, mem_we, mem_wdat, tx_dat, tx_st,
        output mem_rdat, tx_busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Reply sequencer behind the UART block receiver: shares one memory port with receiver
// writes and streams header, optional read data and a CRC-16 to the transmitter.
module uart_cmd_ctrl #(
    parameter logic [15:0] INIT_CRC = 16'hFFFF,
    parameter logic [15:0] XCRC16   = 16'hA001,
    parameter int          AW       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_dat,
    input  logic                   ok_rx_byte,
    input  logic [7:0]             cb_byte,
    input  logic                   ce_wr_dat,
    input  logic [15:0]            wr_adr,
    input  logic [7:0]             com,
    input  logic [7:0]             lbl,
    input  logic                   ok_rx_bl,
    input  logic                   res,
    uart_cmd_ctrl_if.master        bus,
    output logic                   busy,
    output logic [7:0]             err_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, RD, RDW, CRC8, SEND, GUARD, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   base_adr_q, base_adr_d;
    logic [15:0]   rep_adr_q, rep_adr_d;
    logic [7:0]    com_q, com_d;
    logic [7:0]    lbl_q, lbl_d;
    logic [8:0]    idx_q, idx_d;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    crc_hi_q, crc_hi_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    err_q, err_d;
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic          tx_st_c;

    logic          is_read;
    logic          trigger;
    logic [8:0]    n_data;
    logic [8:0]    crc_idx;
    logic [8:0]    last_idx;

    assign is_read  = (com_q == 8'h80) || (com_q == 8'h81);
    assign n_data   = is_read ? {1'b0, lbl_q} : 9'd0;
    assign crc_idx  = 9'd4 + n_data;
    assign last_idx = crc_idx + 9'd1;
    assign trigger  = ok_rx_bl && ((com == 8'h80) || (com == 8'h81) || (com == 8'h01));

    always_comb begin
        state_d    = state_q;
        base_adr_d = base_adr_q;
        rep_adr_d  = rep_adr_q;
        com_d      = com_q;
        lbl_d      = lbl_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        crc_hi_d   = crc_hi_q;
        sh_d       = sh_q;
        tx_byte_d  = tx_byte_q;
        bit_d      = bit_q;
        err_d      = err_q;
        rd_adr_d   = rd_adr_q;
        tx_st_c    = 1'b0;

        if (ok_rx_byte && cb_byte == 8'd2) base_adr_d[15:8] = rx_dat;
        if (ok_rx_byte && cb_byte == 8'd3) base_adr_d[7:0]  = rx_dat;
        if (res && !ok_rx_bl && err_q != 8'hFF) err_d = err_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    // The address is frozen too, so a block arriving mid-reply cannot redirect reads.
                    com_d     = com;
                    lbl_d     = lbl;
                    rep_adr_d = base_adr_q;
                    crc_d     = INIT_CRC;
                    idx_d     = 9'd0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (idx_q < 9'd4) begin
                    case (idx_q[1:0])
                        2'd0:    sh_d = com_q;
                        2'd1:    sh_d = lbl_q;
                        2'd2:    sh_d = rep_adr_q[15:8];
                        default: sh_d = rep_adr_q[7:0];
                    endcase
                    tx_byte_d = sh_d;
                    bit_d     = 3'd0;
                    state_d   = CRC8;
                end else if (idx_q < crc_idx) begin
                    rd_adr_d = AW'(rep_adr_q + (16'(idx_q) - 16'd4));
                    state_d  = RD;
                end else if (idx_q == crc_idx) begin
                    tx_byte_d = crc_q[7:0];
                    crc_hi_d  = crc_q[15:8];
                    state_d   = SEND;
                end else begin
                    tx_byte_d = crc_hi_q;
                    state_d   = SEND;
                end
            end
            RD: begin
                // A receiver write owns the port this cycle; hold the address and retry.
                if (!ce_wr_dat) state_d = RDW;
            end
            RDW: begin
                sh_d      = bus.mem_rdat;
                tx_byte_d = bus.mem_rdat;
                bit_d     = 3'd0;
                state_d   = CRC8;
            end
            CRC8: begin
                crc_d = (crc_q[0] ^ sh_q[0]) ? ((crc_q >> 1) ^ XCRC16) : (crc_q >> 1);
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_st_c = 1'b1;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                idx_d   = idx_q + 9'd1;
                state_d = (idx_q < last_idx) ? LOAD : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_adr_q <= 16'h0000;
            rep_adr_q  <= 16'h0000;
            com_q      <= 8'h00;
            lbl_q      <= 8'h00;
            idx_q      <= 9'd0;
            crc_q      <= INIT_CRC;
            crc_hi_q   <= 8'h00;
            sh_q       <= 8'h00;
            tx_byte_q  <= 8'h00;
            bit_q      <= 3'd0;
            err_q      <= 8'h00;
            rd_adr_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_adr_q <= base_adr_d;
            rep_adr_q  <= rep_adr_d;
            com_q      <= com_d;
            lbl_q      <= lbl_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            crc_hi_q   <= crc_hi_d;
            sh_q       <= sh_d;
            tx_byte_q  <= tx_byte_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            rd_adr_q   <= rd_adr_d;
        end
    end

    assign bus.mem_we   = ce_wr_dat;
    assign bus.mem_wdat = rx_dat;
    assign bus.mem_adr  = ce_wr_dat ? AW'(wr_adr) : rd_adr_q;
    assign bus.tx_dat   = tx_byte_q;
    // Gated by rst so an abort in the SEND state cannot emit a last start pulse.
    assign bus.tx_st    = tx_st_c && !rst;
    assign busy         = (state_q != IDLE);
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: emulated receiver, registered-read memory and a
// transmitter model with programmable busy time.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_dat;
    logic        ok_rx_byte;
    logic [7:0]  cb_byte;
    logic        ce_wr_dat;
    logic [15:0] wr_adr;
    logic [7:0]  com;
    logic [7:0]  lbl;
    logic        ok_rx_bl;
    logic        res;
    logic        busy;
    logic [7:0]  err_cnt;

    uart_cmd_ctrl_if #(.AW(16)) bus ();

    uart_cmd_ctrl #(.INIT_CRC(16'hFFFF), .XCRC16(16'hA001), .AW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_dat     (rx_dat),
        .ok_rx_byte (ok_rx_byte),
        .cb_byte    (cb_byte),
        .ce_wr_dat  (ce_wr_dat),
        .wr_adr     (wr_adr),
        .com        (com),
        .lbl        (lbl),
        .ok_rx_bl   (ok_rx_bl),
        .res        (res),
        .bus        (bus),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Memory model with a preload port for the bench.
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_adr = 16'h0;
    logic [7:0]  pl_dat = 8'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_adr] <= pl_dat;
        else if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdat;
        bus.mem_rdat <= mem[bus.mem_adr];
    end

    // Transmitter model: logs each started byte and stays busy for busy_len clocks.
    int         busy_len = 3;
    int         bcnt = 0;
    int         tx_total = 0;
    int         viol = 0;
    logic [7:0] txlog [0:4095];

    initial bus.tx_busy = 1'b0;

    always @(posedge clk) begin
        if (bus.tx_st) begin
            txlog[tx_total] <= bus.tx_dat;
            tx_total        <= tx_total + 1;
            bus.tx_busy     <= 1'b1;
            bcnt            <= busy_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt        <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) if (bus.tx_st && bus.tx_busy) viol <= viol + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [0:15][7:0] b, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send_block(input logic [0:7][7:0] b, input int nb, input bit good);
        logic [15:0] base;
        base = {b[2], b[3]};
        com  = b[0];
        lbl  = b[1];
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            rx_dat     = b[i];
            cb_byte    = 8'(i);
            ok_rx_byte = 1'b1;
            if (b[0] == 8'h01 && i >= 4) begin
                ce_wr_dat = 1'b1;
                wr_adr    = base + 16'(i - 4);
            end
            @(negedge clk);
            ok_rx_byte = 1'b0;
            ce_wr_dat  = 1'b0;
        end
        @(negedge clk);
        ok_rx_bl = good;
        res      = 1'b1;
        @(negedge clk);
        ok_rx_bl = 1'b0;
        res      = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 20000; n++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s idle_timeout: busy still %0b", nm, busy);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_reply(input string nm, input int t0, input logic [0:7][7:0] e, input int ne);
        logic [0:15][7:0] eb;
        logic [15:0]      c;
        int               n;
        eb = '0;
        n  = ne;
        for (int i = 0; i < ne; i++) eb[i] = e[i];
        if (ne > 0) begin
            c         = crc16(eb, ne);
            eb[ne]    = c[7:0];
            eb[ne+1]  = c[15:8];
            n         = ne + 2;
        end
        chk({nm, " tx_count"}, 32'(tx_total - t0), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s tx_byte[%0d]", nm, i), {24'h0, txlog[t0 + i]}, {24'h0, eb[i]});
    endtask

    typedef struct {
        logic [0:7][7:0] blk;
        int              nb;
        bit              good;
        logic [0:7][7:0] exp;
        int              ne;
        logic [7:0]      exp_err;
    } vec_t;

    vec_t vt [7];
    int   t0;

    initial begin
        vt[0] = '{{8'h80, 8'h03, 8'h12, 8'h30, 32'h0}, 4, 1'b1,
                  {8'h80, 8'h03, 8'h12, 8'h30, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 7, 8'd0};
        vt[1] = '{{8'h01, 8'h02, 8'h00, 8'h10, 8'h55, 8'h66, 16'h0}, 6, 1'b1,
                  {8'h01, 8'h02, 8'h00, 8'h10, 32'h0}, 4, 8'd0};
        vt[2] = '{{8'h80, 8'h02, 8'hFF, 8'hFF, 32'h0}, 4, 1'b1,
                  {8'h80, 8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22, 16'h0}, 6, 8'd0};
        vt[3] = '{{8'h81, 8'h01, 8'h12, 8'h31, 32'h0}, 4, 1'b1,
                  {8'h81, 8'h01, 8'h12, 8'h31, 8'hBB, 24'h0}, 5, 8'd0};
        vt[4] = '{{8'h80, 8'h00, 8'h12, 8'h30, 32'h0}, 4, 1'b1,
                  {8'h80, 8'h00, 8'h12, 8'h30, 32'h0}, 4, 8'd0};
        vt[5] = '{{8'h42, 8'h00, 8'h00, 8'h00, 32'h0}, 4, 1'b1, 64'h0, 0, 8'd0};
        vt[6] = '{{8'h80, 8'h03, 8'h12, 8'h30, 32'h0}, 4, 1'b0, 64'h0, 0, 8'd1};

        rst = 1'b1; rx_dat = 8'h0; ok_rx_byte = 1'b0; cb_byte = 8'h0; ce_wr_dat = 1'b0;
        wr_adr = 16'h0; com = 8'h0; lbl = 8'h0; ok_rx_bl = 1'b0; res = 1'b0;

        preload(16'h1230, 8'hAA);
        preload(16'h1231, 8'hBB);
        preload(16'h1232, 8'hCC);
        preload(16'hFFFF, 8'h11);
        preload(16'h0000, 8'h22);
        @(negedge clk);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset tx_st", {31'h0, bus.tx_st}, 32'h0);
        chk("reset tx_dat", {24'h0, bus.tx_dat}, 32'h0);
        chk("reset err_cnt", {24'h0, err_cnt}, 32'h0);
        chk("reset mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("reset mem_adr", {16'h0, bus.mem_adr}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            t0 = tx_total;
            send_block(vt[v].blk, vt[v].nb, vt[v].good);
            wait_idle($sformatf("vec%0d", v));
            check_reply($sformatf("vec%0d", v), t0, vt[v].exp, vt[v].ne);
            chk($sformatf("vec%0d err_cnt", v), {24'h0, err_cnt}, {24'h0, vt[v].exp_err});
            chk($sformatf("vec%0d busy", v), {31'h0, busy}, 32'h0);
        end
        chk("mem[0010]", {24'h0, mem[16'h0010]}, 32'h55);
        chk("mem[0011]", {24'h0, mem[16'h0011]}, 32'h66);

        // Slow transmitter: long busy after every start.
        busy_len = 500;
        t0 = tx_total;
        send_block(vt[0].blk, 4, 1'b1);
        wait_idle("slow_tx");
        check_reply("slow_tx", t0, vt[0].exp, 7);
        busy_len = 3;

        // Write block arriving while a read reply is in flight.
        busy_len = 20;
        t0 = tx_total;
        send_block(vt[0].blk, 4, 1'b1);
        fork
            wait_idle("overlap");
            begin
                repeat (30) @(negedge clk);
                send_block({8'h01, 8'h02, 8'h20, 8'h00, 8'h77, 8'h88, 16'h0}, 6, 1'b1);
            end
        join
        check_reply("overlap", t0, vt[0].exp, 7);
        chk("overlap mem[2000]", {24'h0, mem[16'h2000]}, 32'h77);
        chk("overlap mem[2001]", {24'h0, mem[16'h2001]}, 32'h88);
        chk("overlap err_cnt", {24'h0, err_cnt}, 32'h1);

        // Reset in the middle of a reply.
        t0 = tx_total;
        send_block(vt[0].blk, 4, 1'b1);
        for (int n = 0; n < 5000; n++) begin
            if (tx_total - t0 >= 2) break;
            @(negedge clk);
        end
        chk("abort started", 32'(tx_total - t0 >= 2), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort err_cnt", {24'h0, err_cnt}, 32'h0);
        rst = 1'b0;
        t0 = tx_total;
        repeat (300) @(negedge clk);
        chk("abort no tx_st", 32'(tx_total - t0), 32'h0);
        chk("abort still idle", {31'h0, busy}, 32'h0);

        chk("tx_st while busy", 32'(viol), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
